alu_decode_stage: RTL
=====================

// Module: alu_decode_stage
// PURPOSE
//  Registered RV32I decode stage and producer of the 4-bit ALU opcode bus consumed by the execute-stage ALU.
//  Accepts fetched instructions via valid/ready and decodes opcode/funct3/funct7 into ALU op, operand selects,
//  immediate, register indices and write enable. Holds one decoded instruction in an output register
//  with valid/ready toward execute. Sits between fetch and execute; flushable on branch redirect.
// PARAMETERS
//  XLEN        32   datapath width; only 32 is supported
//  RESET_PC    0    value driven on out_pc while empty/after reset
// PORTS
//  clk          in   1     single clock, all state updates on rising edge
//  rst          in   1     synchronous, active-high reset
//  flush        in   1     discard held and incoming instruction (branch redirect)
//  in_valid     in   1     fetch presents instruction
//  in_ready     out  1     stage can accept this cycle
//  in_instr     in   32    raw instruction word
//  in_pc        in   32    instruction address
//  out_valid    out  1     decoded instruction held for execute
//  out_ready    in   1     execute consumes this cycle
//  out_alu_op   out  4     ALU opcode (EXE_*_OP encoding)
//  out_op1_sel  out  2     0=rs1, 1=pc, 2=zero
//  out_op2_sel  out  1     0=rs2, 1=imm
//  out_imm      out  32    sign-extended immediate
//  out_rs1/out_rs2/out_rd  out 5 each  register indices
//  out_reg_we   out  1     writes rd (forced 0 when rd==0)
//  out_illegal  out  1     unrecognised encoding
//  out_pc       out  32    pc of held instruction
// BEHAVIOUR
//  - Reset: out_valid=0, out_alu_op=EXE_ADD_OP, selects=0, out_imm/rs/rd=0, reg_we=0, illegal=0, out_pc=RESET_PC.
//  - in_ready = !out_valid | out_ready (combinational; no skid buffer). Transfer in when in_valid&in_ready.
//  - Latency 1: instruction accepted at edge N is presented with out_valid=1 from cycle N+1.
//  - Hold: out_valid&!out_ready -> all out_* stable; in_ready=0.
//  - Empty-out: out_valid&out_ready&!in_valid -> out_valid=0 next cycle; data fields don't-care but not X.
//  - flush: next cycle out_valid=0, incoming instr dropped regardless of in_valid. flush has priority over load.
//  - rst has priority over flush; rst mid-transfer drops the instruction.
//  - Decode (opcode[6:0]):
//    0110011 R: funct3/funct7[5] -> ADD/SUB,SLL,SLT,SLTU,XOR,SRL/SRA,OR,AND; op1=rs1, op2=rs2, we=1.
//      funct7 not in {0x00,0x20}, or 0x20 with funct3 not in {000,101} -> illegal.
//    0010011 I: same map, no SUB (ADDI ignores funct7); SLLI needs funct7=0, SRLI/SRAI funct7 0x00/0x20 else illegal.
//    0110111 LUI: ADD, op1=zero, op2=imm(U). 0010111 AUIPC: ADD, op1=pc, op2=imm(U).
//    0000011 load: ADD rs1+imm(I), we=1. 0100011 store: ADD rs1+imm(S), we=0.
//    1100011 branch: BEQ/BNE->SUB, BLT/BGE->SLT, BLTU/BGEU->SLTU; op2=rs2; we=0; funct3 010/011 illegal.
//    1101111 JAL / 1100111 JALR: ADD, op1=pc / rs1, op2=imm(J)/(I); we=1.
//    Other: illegal=1, alu_op=ADD, we=0, out_valid still 1 (execute raises exception).
//  - Immediates: I/S/B/U/J per RV32I, bit 31 sign-extends; U is {instr[31:12],12'b0}.
//  - rs1/rs2/rd always raw fields instr[19:15]/[24:20]/[11:7]; reg_we gated by rd!=0.
// STRUCTURE
//  - Shared package/header: EXE_*_OP codes (ADD=0,SUB=1,SLL=2,SLT=3,SLTU=4,XOR=5,SRL=6,SRA=7,OR=8,AND=9),
//    RV32I opcode constants, OP1_SEL_*/OP2_SEL_* constants. ALU consumes same header.
//  - One sub-module: rv32i_imm_gen (combinational, instr -> 32-bit imm by format). Decode logic and
//    output register live in this module.
// TESTING
//  - Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_alu_op=0, in_ready=1.
//  - in_instr=0x40B50533 (sub x10,x10,x11) -> next cycle alu_op=1, op2_sel=0, rd=10, reg_we=1.
//  - in_instr=0x4020D093 (srai x1,x1,2) -> alu_op=7, op2_sel=1, imm=2; 0x0020D093 -> alu_op=6.
//  - lui x5,0xFFFFF (0xFFFFF2B7) -> alu_op=0, op1_sel=2, imm=0xFFFFF000; bgeu (0x00B57463) -> alu_op=4, we=0.
//  - Backpressure: out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs stable; release -> next instr loads.
//  - flush with in_valid=1 and held instr -> out_valid=0 next cycle; 0xFFFFFFFF -> out_illegal=1, reg_we=0.

Source files
------------

// File: rtl/alu_decode_stage_pkg.sv
// Shared definitions for the RV32I decode stage and the execute-stage ALU:
// ALU opcode encoding, base opcodes, operand-select codes and immediate formats.
package alu_decode_stage_pkg;

   // ALU opcode bus encoding (4 bits, consumed by the execute-stage ALU)
   localparam logic [3:0] EXE_ADD_OP  = 4'd0;
   localparam logic [3:0] EXE_SUB_OP  = 4'd1;
   localparam logic [3:0] EXE_SLL_OP  = 4'd2;
   localparam logic [3:0] EXE_SLT_OP  = 4'd3;
   localparam logic [3:0] EXE_SLTU_OP = 4'd4;
   localparam logic [3:0] EXE_XOR_OP  = 4'd5;
   localparam logic [3:0] EXE_SRL_OP  = 4'd6;
   localparam logic [3:0] EXE_SRA_OP  = 4'd7;
   localparam logic [3:0] EXE_OR_OP   = 4'd8;
   localparam logic [3:0] EXE_AND_OP  = 4'd9;

   // RV32I base opcodes (instr[6:0])
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Operand selects
   localparam logic [1:0] OP1_SEL_RS1  = 2'd0;
   localparam logic [1:0] OP1_SEL_PC   = 2'd1;
   localparam logic [1:0] OP1_SEL_ZERO = 2'd2;
   localparam logic       OP2_SEL_RS2  = 1'b0;
   localparam logic       OP2_SEL_IMM  = 1'b1;

   // Immediate formats; SHAMT is the zero-extended 5-bit shift amount of SLLI/SRLI/SRAI
   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_SHAMT,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_t;

   // funct3 -> ALU op for OP / OP-IMM; alt selects SUB / SRA
   function automatic logic [3:0] alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
      logic [3:0] op;
      case (funct3)
         3'b000:  op = alt ? EXE_SUB_OP : EXE_ADD_OP;
         3'b001:  op = EXE_SLL_OP;
         3'b010:  op = EXE_SLT_OP;
         3'b011:  op = EXE_SLTU_OP;
         3'b100:  op = EXE_XOR_OP;
         3'b101:  op = alt ? EXE_SRA_OP : EXE_SRL_OP;
         3'b110:  op = EXE_OR_OP;
         default: op = EXE_AND_OP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate generator: selects and sign-extends the
// immediate field of an instruction according to the decoded format.
module rv32i_imm_gen
   import alu_decode_stage_pkg::*;
(
   input  imm_fmt_t    fmt,
   input  logic [31:7] instr_bits,
   output logic [31:0] imm
);

   // Assemble the immediate for the requested format; formats without one yield zero
   always_comb begin
      imm = '0;
      case (fmt)
         IMM_I:     imm = {{20{instr_bits[31]}}, instr_bits[31:20]};
         IMM_SHAMT: imm = {27'b0, instr_bits[24:20]};
         IMM_S:     imm = {{20{instr_bits[31]}}, instr_bits[31:25], instr_bits[11:7]};
         IMM_B:     imm = {{19{instr_bits[31]}}, instr_bits[31], instr_bits[7],
                           instr_bits[30:25], instr_bits[11:8], 1'b0};
         IMM_U:     imm = {instr_bits[31:12], 12'b0};
         IMM_J:     imm = {{11{instr_bits[31]}}, instr_bits[31], instr_bits[19:12],
                           instr_bits[20], instr_bits[30:21], 1'b0};
         default:   imm = '0;
      endcase
   end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage. Decodes one fetched instruction into ALU op,
// operand selects, immediate, register indices and write enable, and holds it
// in a single output register with valid/ready handshakes on both sides.
module alu_decode_stage
   import alu_decode_stage_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_alu_op,
   output logic [1:0]      out_op1_sel,
   output logic            out_op2_sel,
   output logic [XLEN-1:0] out_imm,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic            out_reg_we,
   output logic            out_illegal,
   output logic [XLEN-1:0] out_pc
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rd_field;

   assign opcode   = in_instr[6:0];
   assign funct3   = in_instr[14:12];
   assign funct7   = in_instr[31:25];
   assign rd_field = in_instr[11:7];

   logic [3:0]  alu_op_next;
   logic [1:0]  op1_sel_next;
   logic        op2_sel_next;
   imm_fmt_t    imm_fmt;
   logic        we_raw;
   logic        illegal_next;
   logic        reg_we_next;
   logic [31:0] imm_next;

   logic            valid_reg;
   logic [3:0]      alu_op_reg;
   logic [1:0]      op1_sel_reg;
   logic            op2_sel_reg;
   logic [XLEN-1:0] imm_reg;
   logic [4:0]      rs1_reg;
   logic [4:0]      rs2_reg;
   logic [4:0]      rd_reg;
   logic            reg_we_reg;
   logic            illegal_reg;
   logic [XLEN-1:0] pc_reg;

   rv32i_imm_gen u_imm_gen (
      .fmt        (imm_fmt),
      .instr_bits (in_instr[31:7]),
      .imm        (imm_next)
   );

   // Decode opcode/funct3/funct7 into control fields. Any illegal encoding
   // collapses to a harmless ADD with no writeback so execute only has to
   // look at the illegal flag.
   always_comb begin
      alu_op_next  = EXE_ADD_OP;
      op1_sel_next = OP1_SEL_RS1;
      op2_sel_next = OP2_SEL_RS2;
      imm_fmt      = IMM_NONE;
      we_raw       = 1'b0;
      illegal_next = 1'b0;
      case (opcode)
         OPC_OP: begin
            we_raw      = 1'b1;
            alu_op_next = alu_op_from_funct3(funct3, funct7[5]);
            if (!((funct7 == 7'h00) ||
                  ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
               illegal_next = 1'b1;
         end
         OPC_OP_IMM: begin
            we_raw       = 1'b1;
            op2_sel_next = OP2_SEL_IMM;
            imm_fmt      = IMM_I;
            case (funct3)
               3'b001: begin
                  alu_op_next = EXE_SLL_OP;
                  imm_fmt     = IMM_SHAMT;
                  if (funct7 != 7'h00)
                     illegal_next = 1'b1;
               end
               3'b101: begin
                  alu_op_next = funct7[5] ? EXE_SRA_OP : EXE_SRL_OP;
                  imm_fmt     = IMM_SHAMT;
                  if ((funct7 != 7'h00) && (funct7 != 7'h20))
                     illegal_next = 1'b1;
               end
               default: alu_op_next = alu_op_from_funct3(funct3, 1'b0);
            endcase
         end
         OPC_LUI: begin
            we_raw       = 1'b1;
            op1_sel_next = OP1_SEL_ZERO;
            op2_sel_next = OP2_SEL_IMM;
            imm_fmt      = IMM_U;
         end
         OPC_AUIPC: begin
            we_raw       = 1'b1;
            op1_sel_next = OP1_SEL_PC;
            op2_sel_next = OP2_SEL_IMM;
            imm_fmt      = IMM_U;
         end
         OPC_LOAD: begin
            we_raw       = 1'b1;
            op2_sel_next = OP2_SEL_IMM;
            imm_fmt      = IMM_I;
         end
         OPC_STORE: begin
            op2_sel_next = OP2_SEL_IMM;
            imm_fmt      = IMM_S;
         end
         OPC_BRANCH: begin
            imm_fmt = IMM_B;
            case (funct3[2:1])
               2'b00:   alu_op_next = EXE_SUB_OP;
               2'b10:   alu_op_next = EXE_SLT_OP;
               2'b11:   alu_op_next = EXE_SLTU_OP;
               default: illegal_next = 1'b1;
            endcase
         end
         OPC_JAL: begin
            we_raw       = 1'b1;
            op1_sel_next = OP1_SEL_PC;
            op2_sel_next = OP2_SEL_IMM;
            imm_fmt      = IMM_J;
         end
         OPC_JALR: begin
            we_raw       = 1'b1;
            op2_sel_next = OP2_SEL_IMM;
            imm_fmt      = IMM_I;
         end
         default: illegal_next = 1'b1;
      endcase
      if (illegal_next) begin
         alu_op_next  = EXE_ADD_OP;
         op1_sel_next = OP1_SEL_RS1;
         op2_sel_next = OP2_SEL_RS2;
         imm_fmt      = IMM_NONE;
         we_raw       = 1'b0;
      end
   end

   // x0 is never written
   assign reg_we_next = we_raw & (rd_field != 5'd0);

   // No skid buffer: accept only when the output register is empty or draining
   assign in_ready = !valid_reg || out_ready;

   // Output register: reset beats flush, flush beats load, otherwise drain on consume
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg   <= 1'b0;
         alu_op_reg  <= EXE_ADD_OP;
         op1_sel_reg <= OP1_SEL_RS1;
         op2_sel_reg <= OP2_SEL_RS2;
         imm_reg     <= '0;
         rs1_reg     <= '0;
         rs2_reg     <= '0;
         rd_reg      <= '0;
         reg_we_reg  <= 1'b0;
         illegal_reg <= 1'b0;
         pc_reg      <= RESET_PC;
      end else if (flush) begin
         valid_reg <= 1'b0;
      end else if (in_valid && in_ready) begin
         valid_reg   <= 1'b1;
         alu_op_reg  <= alu_op_next;
         op1_sel_reg <= op1_sel_next;
         op2_sel_reg <= op2_sel_next;
         imm_reg     <= imm_next;
         rs1_reg     <= in_instr[19:15];
         rs2_reg     <= in_instr[24:20];
         rd_reg      <= rd_field;
         reg_we_reg  <= reg_we_next;
         illegal_reg <= illegal_next;
         pc_reg      <= in_pc;
      end else if (out_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign out_valid   = valid_reg;
   assign out_alu_op  = alu_op_reg;
   assign out_op1_sel = op1_sel_reg;
   assign out_op2_sel = op2_sel_reg;
   assign out_imm     = imm_reg;
   assign out_rs1     = rs1_reg;
   assign out_rs2     = rs2_reg;
   assign out_rd      = rd_reg;
   assign out_reg_we  = reg_we_reg;
   assign out_illegal = illegal_reg;
   assign out_pc      = pc_reg;

endmodule
